// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: divides clk into a pixel strobe and
// produces registered sync, blanking, coordinates and line/frame pulses.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int X_W      = 10,
    parameter int Y_W      = 10
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           en,
    output logic           pix_en,
    output logic           vga_clk,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic           blank_n,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           line_start,
    output logic           frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [X_W-1:0]   H_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0]   V_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic             HS_ON    = (HS_POL != 0);
    localparam logic             VS_ON    = (VS_POL != 0);

    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic [X_W-1:0]   h_cnt, h_nxt;
    logic [Y_W-1:0]   v_cnt, v_nxt;
    logic             h_wrap, v_wrap;
    logic             line_q, frame_q;

    function automatic logic in_window(input int val, input int lo, input int hi);
        return (val >= lo) && (val < hi);
    endfunction

    always_comb begin
        div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        h_wrap  = (h_cnt == H_LAST);
        v_wrap  = (v_cnt == V_LAST);
        h_nxt   = h_wrap ? '0 : h_cnt + 1'b1;
        v_nxt   = v_cnt;
        if (h_wrap) begin
            v_nxt = v_wrap ? '0 : v_cnt + 1'b1;
        end
    end

    assign pix_en = en && (div_cnt == DIV_LAST);

    // Decode is computed from the next counter values so every output changes
    // on the same edge as the counters it describes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_cnt <= '0;
            h_cnt   <= H_LAST;
            v_cnt   <= V_LAST;
            vga_clk <= 1'b0;
            hsync   <= ~HS_ON;
            vsync   <= ~VS_ON;
            de      <= 1'b0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            line_q  <= 1'b0;
            frame_q <= 1'b0;
            if (en) begin
                div_cnt <= div_nxt;
                vga_clk <= (int'(div_nxt) >= CLK_DIV / 2);
                if (pix_en) begin
                    h_cnt   <= h_nxt;
                    v_cnt   <= v_nxt;
                    de      <= in_window(int'(h_nxt), 0, H_ACTIVE) &&
                               in_window(int'(v_nxt), 0, V_ACTIVE);
                    hsync   <= in_window(int'(h_nxt), H_ACTIVE + H_FP,
                                         H_ACTIVE + H_FP + H_SYNC) ? HS_ON : ~HS_ON;
                    vsync   <= in_window(int'(v_nxt), V_ACTIVE + V_FP,
                                         V_ACTIVE + V_FP + V_SYNC) ? VS_ON : ~VS_ON;
                    line_q  <= h_wrap;
                    frame_q <= h_wrap && v_wrap;
                end
            end
        end
    end

    // Pulses are suppressed while frozen so a stalled pixel is never announced twice.
    assign line_start  = line_q && en;
    assign frame_start = frame_q && en;
    assign blank_n     = de;
    assign x           = h_cnt;
    assign y           = v_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance and a tiny 8x4 instance
// driven by shared random en/resetn, checked every cycle against a position model.
module tb_vga_timing_gen;

    typedef struct {
        int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, div, hpol, vpol;
    } cfg_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       en = 1'b1;
    logic       pix_en[2], vga_clk[2], hsync[2], vsync[2], de[2], blank_n[2];
    logic       line_start[2], frame_start[2];
    logic [9:0] x[2], y[2];

    int     checks = 0;
    int     errors = 0;
    bit     phase1 = 1'b0;
    bit     mvalid = 1'b0;
    longint ecnt[2];
    bit     lastpix[2];

    always #5 clk = ~clk;

    vga_timing_gen dut0 (
        .clk(clk), .resetn(resetn), .en(en),
        .pix_en(pix_en[0]), .vga_clk(vga_clk[0]), .hsync(hsync[0]), .vsync(vsync[0]),
        .de(de[0]), .blank_n(blank_n[0]), .x(x[0]), .y(y[0]),
        .line_start(line_start[0]), .frame_start(frame_start[0])
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(4), .HS_POL(1), .VS_POL(0)
    ) dut1 (
        .clk(clk), .resetn(resetn), .en(en),
        .pix_en(pix_en[1]), .vga_clk(vga_clk[1]), .hsync(hsync[1]), .vsync(vsync[1]),
        .de(de[1]), .blank_n(blank_n[1]), .x(x[1]), .y(y[1]),
        .line_start(line_start[1]), .frame_start(frame_start[1])
    );

    function automatic cfg_t get_cfg(input int i);
        cfg_t c;
        if (i == 0) c = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 0, 0};
        else        c = '{8, 1, 2, 1, 4, 1, 1, 1, 4, 1, 0};
        return c;
    endfunction

    task automatic chk(input string name, input int idx, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d at enabled-clk %0d: got %0d, expected %0d",
                     name, idx, ecnt[idx], act, exp);
        end
    endtask

    // Model: the raster position is simply (pixels since reset - 1) mod frame size.
    always @(posedge clk) begin
        if (!resetn) begin
            mvalid <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                ecnt[i]    <= 0;
                lastpix[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                cfg_t c;
                c = get_cfg(i);
                if (en) begin
                    lastpix[i] <= (ecnt[i] % c.div) == (c.div - 1);
                    ecnt[i]    <= ecnt[i] + 1;
                end else begin
                    lastpix[i] <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            for (int i = 0; i < 2; i++) begin
                cfg_t   c;
                longint ht, vt, npix, pos;
                int     h, v;
                bit     e_hs, e_vs, e_ls;
                c    = get_cfg(i);
                ht   = c.ha + c.hfp + c.hsw + c.hbp;
                vt   = c.va + c.vfp + c.vsw + c.vbp;
                npix = ecnt[i] / c.div;
                pos  = (npix + ht * vt - 1) % (ht * vt);
                h    = int'(pos % ht);
                v    = int'(pos / ht);
                e_hs = (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hsw) ? (c.hpol != 0) : (c.hpol == 0);
                e_vs = (v >= c.va + c.vfp && v < c.va + c.vfp + c.vsw) ? (c.vpol != 0) : (c.vpol == 0);
                e_ls = en && lastpix[i] && (h == 0);
                chk("x", i, x[i], h);
                chk("y", i, y[i], v);
                chk("pix_en", i, pix_en[i], en && ((ecnt[i] % c.div) == c.div - 1));
                chk("vga_clk", i, vga_clk[i], (ecnt[i] % c.div) >= (c.div / 2));
                chk("de", i, de[i], (h < c.ha) && (v < c.va));
                chk("blank_n", i, blank_n[i], (h < c.ha) && (v < c.va));
                chk("hsync", i, hsync[i], e_hs);
                chk("vsync", i, vsync[i], e_vs);
                chk("line_start", i, line_start[i], e_ls);
                chk("frame_start", i, frame_start[i], e_ls && (v == 0));
            end
            if (phase1) begin
                // Hand-computed anchors for the model on the first clean run.
                case (ecnt[0])
                    0: begin
                        chk("pin0_rst_x", 0, x[0], 799);
                        chk("pin0_rst_y", 0, y[0], 524);
                        chk("pin0_rst_pix", 0, pix_en[0], 0);
                        chk("pin0_rst_hs", 0, hsync[0], 1);
                    end
                    1: chk("pin0_first_pix", 0, pix_en[0], 1);
                    2: begin
                        chk("pin0_x0", 0, x[0], 0);
                        chk("pin0_y0", 0, y[0], 0);
                        chk("pin0_de", 0, de[0], 1);
                        chk("pin0_fs", 0, frame_start[0], 1);
                        chk("pin0_ls", 0, line_start[0], 1);
                        chk("pin0_vs", 0, vsync[0], 1);
                    end
                    1313: chk("pin0_hs_before", 0, hsync[0], 1);
                    1314: begin
                        chk("pin0_hs_x", 0, x[0], 656);
                        chk("pin0_hs_low", 0, hsync[0], 0);
                    end
                    1506: chk("pin0_hs_end", 0, hsync[0], 1);
                    1602: begin
                        chk("pin0_line1_x", 0, x[0], 0);
                        chk("pin0_line1_y", 0, y[0], 1);
                        chk("pin0_line1_ls", 0, line_start[0], 1);
                        chk("pin0_line1_fs", 0, frame_start[0], 0);
                    end
                    default: ;
                endcase
                case (ecnt[1])
                    1: chk("pin1_vclk_lo", 1, vga_clk[1], 0);
                    2: chk("pin1_vclk_hi", 1, vga_clk[1], 1);
                    4: chk("pin1_fs0", 1, frame_start[1], 1);
                    40: begin
                        chk("pin1_hs_x", 1, x[1], 9);
                        chk("pin1_hs_hi", 1, hsync[1], 1);
                    end
                    48: begin
                        chk("pin1_x11", 1, x[1], 11);
                        chk("pin1_hs_off", 1, hsync[1], 0);
                    end
                    340: begin
                        chk("pin1_fs1", 1, frame_start[1], 1);
                        chk("pin1_fs1_y", 1, y[1], 0);
                    end
                    default: ;
                endcase
            end
        end
    end

    initial begin
        resetn = 1'b0;
        en     = 1'b1;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        phase1 = 1'b1;
        repeat (1700) @(posedge clk);
        #1 phase1 = 1'b0;
        en = 1'b0;
        repeat (10) @(posedge clk);
        #1 en = 1'b1;
        repeat (537) @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        repeat (30000) begin
            @(posedge clk);
            #1;
            en     = ($urandom_range(0, 5) != 0);
            resetn = ($urandom_range(0, 2999) != 0);
        end
        @(posedge clk);
        #1 en = 1'b1;
        resetn = 1'b1;
        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; successor to the fixed 640x480 controller plus separate 25 MHz clock divider.
- Divides the system clock internally into a pixel-enable strobe and generates hsync, vsync, blank and data-enable.
- Outputs current pixel coordinates and frame/line pulses.
- Sits between the board clock and the pixel source/framebuffer; drives the ADV7123 pins (VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N) at top level.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 2, clk cycles per pixel; integer >= 2
HS_POL, 0, hsync asserted level
VS_POL, 0, vsync asserted level
X_W, 10, width of x counter; must hold H_TOTAL-1
Y_W, 10, width of y counter; must hold V_TOTAL-1

Ports:
clk  in  1  system clock (50 MHz CLOCK_50)
resetn  in  1  synchronous active-low reset
en  in  1  run enable; 0 freezes all timing
pix_en  out  1  one-clk strobe per pixel period
vga_clk  out  1  pixel clock to DAC, registered
hsync  out  1  horizontal sync, polarity HS_POL
vsync  out  1  vertical sync, polarity VS_POL
de  out  1  1 when current pixel is visible
blank_n  out  1  equal to de
x  out  X_W  horizontal counter value
y  out  Y_W  vertical counter value
line_start  out  1  one-clk pulse on the pix_en that enters h=0
frame_start  out  1  one-clk pulse on the pix_en that enters (0,0)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 at defaults); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 at defaults).
- Reset (resetn=0 at a clk edge): div_cnt=0, h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1. Resulting outputs: pix_en=0, vga_clk=0, hsync=!HS_POL, vsync=!VS_POL, de=blank_n=0, x=H_TOTAL-1, y=V_TOTAL-1, line_start=frame_start=0. Reset overrides en and takes effect mid-frame or mid-pixel.
- Divider:
  - When en=1, div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_en=1 exactly while div_cnt==CLK_DIV-1 and en=1.
  - vga_clk = (div_cnt >= CLK_DIV/2), registered; rising edge falls mid-pixel, giving a 50% duty cycle for even CLK_DIV.
- Counters:
  - Advance only on clk edges where pix_en=1.
  - h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps from V_TOTAL-1 to 0 at the same edge h wraps.
  - No other wrap points; counters never exceed TOTAL-1.
- Decode: all outputs are registered and change on the same edge as the counters, with no extra pipeline latency. x=h_cnt, y=v_cnt.
  - de = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
  - hsync = HS_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else !HS_POL.
  - vsync = VS_POL when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, else !VS_POL. vsync is line-aligned and changes only at h wrap.
- Pulses:
  - line_start=1 for the single clk after the edge where h wraps to 0.
  - frame_start=1 for the single clk after the edge where h and v both wrap. frame_start implies line_start.
- First frame: the first pix_en after reset moves counters to (0,0), so frame_start and line_start fire and de goes to 1 on that edge.
- en=0: div_cnt, counters and all level outputs hold their values; pix_en, line_start and frame_start are 0. Resuming continues from the held div_cnt with no skipped or duplicated pixels.

Test Plan:
- Defaults, resetn low 3 clks then high, en=1 -> pix_en first high 1 clk after release (div_cnt=1); next edge x=0, y=0, de=1, frame_start=1, line_start=1, hsync=1, vsync=1.
- Free-run one line -> hsync low for exactly 96 pix_en periods (192 clks), starting when x=656; de high for x=0..639; line period 1600 clks.
- Free-run one frame -> vsync low while y=490..491 (2 lines = 3200 clks); frame_start period exactly 840000 clks; x never exceeds 799, y never exceeds 524.
- en held low 10 clks at x=100 -> x, y, hsync, vga_clk frozen, pix_en=0; after en=1, the next pix_en gives x=101.
- resetn pulsed low for 1 clk at x=300, y=200 -> next cycle x=799, y=524, de=0, sync outputs inactive; frame restarts cleanly.
- Override CLK_DIV=4, H_ACTIVE=8, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, HS_POL=1 -> line 48 clks; hsync high while x=9..10; frame_start every 336 clks; vga_clk high 2 of 4 clks.
